// File: rtl/signed_sort_ctrl_pkg.sv
// Package: signed_sort_ctrl_pkg
// Purpose: shared types and defaults for the signed sort controller.
//   state_e  - FSM encoding (LOAD=0, SORT=1, DRAIN=2; code 3 is illegal)
//   DefW     - default sample width
//   DefN     - default samples per batch
package signed_sort_ctrl_pkg;

  localparam int unsigned DefW = 4;
  localparam int unsigned DefN = 4;

  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StSort  = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/signed_sort_ctrl_lt.sv
// Module: signed_lt
// Purpose: combinational two's complement less-than comparator.
// Ports:
//   i_a  in   W  left operand
//   i_b  in   W  right operand
//   o_lt out  1  high when signed(i_a) < signed(i_b)
module signed_lt #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_lt
);

  assign o_lt = $signed(i_a) < $signed(i_b);

endmodule

// File: rtl/signed_sort_ctrl.sv
// Module: signed_sort_ctrl
// Purpose: collects N signed samples, bubble-sorts them in place ascending using one shared
//   comparator (one compare-and-swap per cycle), then streams them out smallest first.
// Ports:
//   i_clk       in   1  rising-edge clock
//   i_reset     in   1  synchronous active-high reset
//   i_in_valid  in   1  input sample valid
//   o_in_ready  out  1  block accepts a sample (LOAD)
//   i_in_data   in   W  signed input sample
//   o_out_valid out  1  output sample valid (DRAIN)
//   i_out_ready in   1  downstream accepts output sample
//   o_out_data  out  W  sorted sample, smallest first
//   o_busy      out  1  high while sorting
module signed_sort_ctrl
  import signed_sort_ctrl_pkg::*;
#(
  parameter int unsigned W = DefW,
  parameter int unsigned N = DefN
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data,
  output logic         o_busy
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = IdxW + 1;

  state_e          r_state;
  state_e          w_state_d;
  logic [W-1:0]    r_mem [N];
  logic [CntW-1:0] r_ld_cnt;
  logic [CntW-1:0] r_idx;
  logic [CntW-1:0] r_pass;
  logic [CntW-1:0] r_rd_cnt;
  logic            r_swap;

  logic            w_in_fire;
  logic            w_out_fire;
  logic [IdxW-1:0] w_ia;
  logic [IdxW-1:0] w_ib;
  logic [W-1:0]    w_a;
  logic [W-1:0]    w_b;
  logic            w_lt;
  logic            w_last_ld;
  logic            w_pass_end;
  logic            w_sort_done;
  logic            w_last_rd;

  assign w_in_fire  = i_in_valid & o_in_ready;
  assign w_out_fire = o_out_valid & i_out_ready;

  // Adjacent pair under comparison this cycle.
  assign w_ia = r_idx[IdxW-1:0];
  assign w_ib = w_ia + IdxW'(1);
  assign w_a  = r_mem[w_ia];
  assign w_b  = r_mem[w_ib];

  // lt = b < a: swap only on strict inversion, so equal values keep their order.
  signed_lt #(
    .W (W)
  ) u_lt (
    .i_a  (w_b),
    .i_b  (w_a),
    .o_lt (w_lt)
  );

  assign w_last_ld  = (r_ld_cnt == CntW'(N - 1));
  assign w_pass_end = (r_idx == CntW'(N - 2));
  // A pass with no swap (including the current compare) means the array is sorted;
  // pass N-2 is the last one bubble sort can ever need.
  assign w_sort_done = w_pass_end && ((!r_swap && !w_lt) || (r_pass == CntW'(N - 2)));
  assign w_last_rd  = (r_rd_cnt == CntW'(N - 1));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StLoad;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; the illegal code falls to the default and recovers to LOAD.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StLoad:  if (w_in_fire && w_last_ld) w_state_d = StSort;
      StSort:  if (w_sort_done) w_state_d = StDrain;
      StDrain: if (w_out_fire && w_last_rd) w_state_d = StLoad;
      default: w_state_d = StLoad;
    endcase
  end

  // Outputs decode registered state only.
  always_comb begin
    o_in_ready  = (r_state == StLoad);
    o_out_valid = (r_state == StDrain);
    o_busy      = (r_state == StSort);
    o_out_data  = r_mem[r_rd_cnt[IdxW-1:0]];
  end

  // Datapath: counters, swap flag and sample storage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ld_cnt <= '0;
      r_idx    <= '0;
      r_pass   <= '0;
      r_rd_cnt <= '0;
      r_swap   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_mem[k] <= '0;
      end
    end else begin
      case (r_state)
        StLoad: begin
          if (w_in_fire) begin
            r_mem[r_ld_cnt[IdxW-1:0]] <= i_in_data;
            if (w_last_ld) begin
              r_ld_cnt <= '0;
              r_idx    <= '0;
              r_pass   <= '0;
              r_swap   <= 1'b0;
            end else begin
              r_ld_cnt <= r_ld_cnt + CntW'(1);
            end
          end
        end
        StSort: begin
          if (w_lt) begin
            r_mem[w_ia] <= w_b;
            r_mem[w_ib] <= w_a;
            r_swap      <= 1'b1;
          end
          if (!w_pass_end) begin
            r_idx <= r_idx + CntW'(1);
          end else begin
            r_pass <= r_pass + CntW'(1);
            if (w_sort_done) begin
              r_rd_cnt <= '0;
            end else begin
              // Overrides the swap set above: a new pass starts with a clean flag.
              r_idx  <= '0;
              r_swap <= 1'b0;
            end
          end
        end
        StDrain: begin
          if (w_out_fire) begin
            r_rd_cnt <= r_rd_cnt + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_sort_ctrl.sv
module tb_signed_sort_ctrl;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;

  int n_tests;
  int n_fail;

  signed_sort_ctrl #(
    .W (4),
    .N (4)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string name);
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s: in_ready=%b out_valid=%b busy=%b out_data=%b, want 1 0 0 0000",
               name, in_ready, out_valid, busy, out_data);
    end
  endtask

  // Loads four samples; in_valid stays high afterwards when keep_valid is set.
  task automatic load4(input string name, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [3:0] s2, input logic [3:0] s3, input bit keep_valid);
    logic [3:0] s [4];
    int n;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = s[i];
      n = 0;
      while (!in_ready && n < 100) begin
        step();
        n++;
      end
      if (n >= 100) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s load timeout: in_ready=%b, want 1", name, in_ready);
      end
      step();
    end
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Counts busy cycles, also checking that input is blocked while sorting.
  task automatic wait_sort(input string name, input int exp_cycles, input bit exact);
    int cnt;
    int blocked_err;
    cnt = 0;
    blocked_err = 0;
    while (busy === 1'b1 && cnt < 100) begin
      if (in_ready !== 1'b0) blocked_err++;
      cnt++;
      step();
    end
    n_tests++;
    if (exact ? (cnt != exp_cycles) : (cnt > exp_cycles || cnt == 0)) begin
      n_fail++;
      $display("FAIL %s busy cycles: got %0d, want %s%0d", name, cnt, exact ? "" : "<=",
               exp_cycles);
    end
    n_tests++;
    if (blocked_err != 0) begin
      n_fail++;
      $display("FAIL %s in_ready during sort: high on %0d cycles, want 0", name, blocked_err);
    end
  endtask

  task automatic drain4(input string name, input logic [3:0] s0, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [3:0] s3);
    logic [3:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== s[i]) begin
        n_fail++;
        $display("FAIL %s out[%0d]: valid=%b data=%b, want valid=1 data=%b",
                 name, i, out_valid, out_data, s[i]);
      end
      step();
    end
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s after drain: out_valid=%b in_ready=%b, want 0 1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_idle("reset");
  endtask

  task automatic test_mixed();
    load4("mixed", 4'b0001, 4'b1110, 4'b1011, 4'b0111, 1'b0);
    wait_sort("mixed", 9, 1'b0);
    drain4("mixed", 4'b1011, 4'b1110, 4'b0001, 4'b0111);
  endtask

  task automatic test_presorted();
    load4("presorted", 4'b1000, 4'b1111, 4'b0000, 4'b0111, 1'b0);
    wait_sort("presorted", 3, 1'b1);
    drain4("presorted", 4'b1000, 4'b1111, 4'b0000, 4'b0111);
  endtask

  task automatic test_reverse();
    load4("reverse", 4'b0111, 4'b0010, 4'b1111, 4'b1000, 1'b0);
    wait_sort("reverse", 9, 1'b1);
    drain4("reverse", 4'b1000, 4'b1111, 4'b0010, 4'b0111);
  endtask

  task automatic test_duplicates();
    load4("dups", 4'b1111, 4'b1111, 4'b0110, 4'b1100, 1'b0);
    wait_sort("dups", 9, 1'b1);
    drain4("dups", 4'b1100, 4'b1111, 4'b1111, 4'b0110);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    load4("bp", 4'b0111, 4'b0010, 4'b1111, 4'b1000, 1'b0);
    wait_sort("bp", 9, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 4'b1000) begin
        n_fail++;
        $display("FAIL bp hold cycle %0d: valid=%b data=%b, want valid=1 data=1000",
                 i, out_valid, out_data);
      end
      step();
    end
    drain4("bp", 4'b1000, 4'b1111, 4'b0010, 4'b0111);
  endtask

  // in_valid held high across LOAD->SORT: the fifth sample must wait and lead the next batch.
  task automatic test_back_to_back();
    load4("b2b1", 4'b0001, 4'b1110, 4'b1011, 4'b0111, 1'b1);
    in_data = 4'b0101;
    wait_sort("b2b1", 9, 1'b1);
    drain4("b2b1", 4'b1011, 4'b1110, 4'b0001, 4'b0111);
    load4("b2b2", 4'b0101, 4'b0011, 4'b1001, 4'b0000, 1'b0);
    wait_sort("b2b2", 9, 1'b1);
    drain4("b2b2", 4'b1001, 4'b0000, 4'b0011, 4'b0101);
  endtask

  task automatic test_reset_mid_sort();
    load4("midrst", 4'b0111, 4'b0010, 4'b1111, 4'b1000, 1'b0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst sort entry: busy=%b, want 1", busy);
    end
    step();
    do_reset();
    check_idle("midrst post-reset");
    load4("midrst2", 4'b0010, 4'b1101, 4'b0100, 4'b1110, 1'b0);
    wait_sort("midrst2", 9, 1'b1);
    drain4("midrst2", 4'b1101, 4'b1110, 4'b0010, 4'b0100);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'b0000;
    out_ready = 1'b1;
    step();
    test_reset();
    test_mixed();
    test_presorted();
    test_reverse();
    test_duplicates();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_sort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
